// File: rtl/read_arbiter_pkg.sv
// Shared definitions for read_arbiter: FSM state encoding, default sizes and the stall-timeout limit.
package read_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        REQ  = 2'd2,
        XFER = 2'd3
    } arb_state_t;

    localparam int         DEF_DATA_W    = 256;
    localparam int         DEF_NUM_PORTS = 16;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

    // A programmed weight of zero still allows one packet per turn.
    function automatic logic [3:0] eff_weight(input logic [3:0] w);
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational masked lowest-set-bit finder: first set request at or above start_i, wrapping to index 0.
module rr_pick #(
    parameter int N  = 16,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] start_i,
    output logic [PW-1:0] grant_o,
    output logic          any_o
);

    int            sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = int'(start_i) + i;
            if (sum >= N) sum = sum - N;
            idx = PW'(sum);
            if (!found && req_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/read_arbiter.sv
// read_arbiter: picks a port with queued packets (strict priority or weighted round robin), requests
// it from the SRAM controller and streams its beats to that port. READ_ARB_TIMEOUT_EN adds a stall watchdog.
module read_arbiter
    import read_arbiter_pkg::*;
#(
    parameter  int arbiter_data_width = DEF_DATA_W,
    parameter  int num_of_ports       = DEF_NUM_PORTS,
    localparam int PW                 = (num_of_ports > 1) ? $clog2(num_of_ports) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sp0_wrr1,
    input  logic [num_of_ports-1:0]       pending,
    input  logic [4*num_of_ports-1:0]     wrr_weight_p,
    input  logic [num_of_ports-1:0]       ready,
    output logic                          rd_req,
    output logic [PW-1:0]                 rd_port,
    input  logic                          rd_ack,
    input  logic                          mem_vld,
    input  logic                          mem_sop,
    input  logic                          mem_eop,
    input  logic [arbiter_data_width-1:0] mem_data,
    output logic                          mem_next,
    output logic [num_of_ports-1:0]       vld,
    output logic [num_of_ports-1:0]       sop,
    output logic [num_of_ports-1:0]       eop,
    output logic [arbiter_data_width-1:0] data_out,
    output logic                          busy,
    output logic                          err
);

    arb_state_t              state_q;
    logic [PW-1:0]           sel_q, ptr_q;
    logic [3:0]              credit_q;

    logic [PW-1:0]           grant_d, ptr_d, pick_start, pick_idx;
    logic [3:0]              credit_d, ptr_weight;
    logic                    grant_vld_d, pick_any, keep_ptr, tmo_hit, xfer;
    logic [num_of_ports-1:0] sel_onehot;

    assign ptr_weight = eff_weight(wrr_weight_p[{ptr_q, 2'b00} +: 4]);
    assign keep_ptr   = pending[ptr_q] && (credit_q < ptr_weight);
    assign pick_start = !sp0_wrr1 ? '0 :
                        (ptr_q == PW'(num_of_ports - 1)) ? '0 : ptr_q + 1'b1;

    rr_pick #(.N(num_of_ports), .PW(PW)) u_pick (
        .req_i   (pending),
        .start_i (pick_start),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    // WRR: stay on the pointer port while it has credit, otherwise move to the next requester.
    always_comb begin
        grant_d     = pick_idx;
        grant_vld_d = pick_any;
        ptr_d       = ptr_q;
        credit_d    = credit_q;
        if (sp0_wrr1) begin
            if (keep_ptr) begin
                grant_d     = ptr_q;
                grant_vld_d = 1'b1;
                credit_d    = credit_q + 4'd1;
            end else if (pick_any) begin
                ptr_d    = pick_idx;
                credit_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            ptr_q    <= PW'(num_of_ports - 1);
            credit_q <= '0;
        end else if (tmo_hit) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (|pending) state_q <= ARB;
                ARB: begin
                    if (grant_vld_d) begin
                        sel_q    <= grant_d;
                        ptr_q    <= ptr_d;
                        credit_q <= credit_d;
                        state_q  <= REQ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REQ:  if (rd_ack) state_q <= XFER;
                XFER: if (mem_next && mem_eop) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef READ_ARB_TIMEOUT_EN
    logic [7:0] tmo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (!(state_q == REQ || state_q == XFER) || tmo_hit ||
                     (state_q == REQ && rd_ack) || mem_next) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 8'd1;
        end
    end

    assign tmo_hit = (state_q == REQ || state_q == XFER) && (tmo_q == TIMEOUT_LIMIT);
`else
    assign tmo_hit = 1'b0;
`endif

    // Beat path is combinational so SRAM data reaches the port with zero latency.
    assign xfer       = (state_q == XFER);
    assign sel_onehot = {{(num_of_ports-1){1'b0}}, 1'b1} << sel_q;
    assign mem_next   = xfer && mem_vld && ready[sel_q];
    assign vld        = (xfer && mem_vld)            ? sel_onehot : '0;
    assign sop        = (xfer && mem_vld && mem_sop) ? sel_onehot : '0;
    assign eop        = (xfer && mem_vld && mem_eop) ? sel_onehot : '0;
    assign data_out   = xfer ? mem_data : '0;
    assign rd_req     = (state_q == REQ);
    assign rd_port    = rd_req ? sel_q : '0;
    assign busy       = (state_q != IDLE);
    assign err        = tmo_hit;

endmodule

// File: tb/tb_read_arbiter.sv
// Scoreboard bench for read_arbiter: per-port packet queues, an SRAM responder and an arbitration reference model.
`timescale 1ns/1ps
module tb_read_arbiter;

    localparam int DW = 256;
    localparam int NP = 16;

    typedef struct packed { logic [31:0] seed; logic [31:0] len; } pkt_t;
    typedef struct packed {
        logic [3:0]  port;
        logic [31:0] seed;
        logic [31:0] beat;
        logic        sop;
        logic        eop;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst, sp0_wrr1, rd_ack, mem_vld, mem_sop, mem_eop;
    logic [NP-1:0]   pending, ready;
    logic [4*NP-1:0] wrr_weight_p;
    logic [DW-1:0]   mem_data;
    logic            rd_req, mem_next, busy, err;
    logic [3:0]      rd_port;
    logic [NP-1:0]   vld, sop, eop;
    logic [DW-1:0]   data_out;

    read_arbiter #(.arbiter_data_width(DW), .num_of_ports(NP)) dut (
        .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .pending(pending),
        .wrr_weight_p(wrr_weight_p), .ready(ready), .rd_req(rd_req), .rd_port(rd_port),
        .rd_ack(rd_ack), .mem_vld(mem_vld), .mem_sop(mem_sop), .mem_eop(mem_eop),
        .mem_data(mem_data), .mem_next(mem_next), .vld(vld), .sop(sop), .eop(eop),
        .data_out(data_out), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    pkt_t       pq [NP][$];
    logic [3:0] exp_port_q [$];
    beat_t      exp_beat_q [$];
    int         n_checks = 0;
    int         n_pass = 0;
    bit         in_xfer = 1'b0;
    logic [3:0] cur_port = 4'd0;
    int         m_cur = NP - 1;
    int         m_run = 0;

    task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] word(input logic [31:0] seed, input logic [31:0] b);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = seed ^ (b * 32'h9E3779B9) ^ (32'(k) * 32'd7);
        return w;
    endfunction

    function automatic logic [NP-1:0] oh(input logic [3:0] p);
        return 16'd1 << p;
    endfunction

    // Reference arbitration: m_cur is the port holding the WRR turn, m_run how many packets it took this turn.
    function automatic int arb_model(input logic [NP-1:0] pend, input bit wrr, input logic [4*NP-1:0] w);
        int budget, c;
        if (!wrr) begin
            for (int i = 0; i < NP; i++) if (pend[i]) return i;
            return -1;
        end
        budget = int'(w[4*m_cur +: 4]);
        if (budget == 0) budget = 1;
        if (pend[m_cur] && m_run < budget) begin
            m_run++;
            return m_cur;
        end
        for (int k = 1; k <= NP; k++) begin
            c = (m_cur + k) % NP;
            if (pend[c]) begin
                m_cur = c;
                m_run = 1;
                return c;
            end
        end
        return -1;
    endfunction

    function automatic void add_pkt(input int p, input int len);
        pkt_t k;
        k.seed = $urandom;
        k.len  = 32'(len);
        pq[p].push_back(k);
    endfunction

    function automatic void upd_pending();
        for (int i = 0; i < NP; i++) pending[i] = (pq[i].size() != 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serves one packet as the SRAM controller; hold_beat stalls that beat 2 cycles, rst_beat resets during it.
    task automatic serve_one(input int hold_beat, input int rst_beat);
        int g, lat, hold, tries;
        bit done;
        pkt_t pk;
        beat_t eb;
        logic [NP-1:0] rdy;
        g = arb_model(pending, sp0_wrr1, wrr_weight_p);
        if (g < 0) begin
            check(1'b0, "model_no_grant", pending, 0);
            return;
        end
        pk = pq[g][0];
        exp_port_q.push_back(g[3:0]);
        for (int b = 0; b < int'(pk.len); b++) begin
            if (rst_beat < 0 || b < rst_beat) begin
                eb.port = g[3:0]; eb.seed = pk.seed; eb.beat = 32'(b);
                eb.sop = (b == 0); eb.eop = (b == int'(pk.len) - 1);
                exp_beat_q.push_back(eb);
            end
        end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!rd_req && lat < 20);
        check(lat == 2, "req_latency", 32'(lat), 2);
        if (!rd_req) return;
        repeat ($urandom_range(0, 2)) tick();
        rd_ack = 1'b1;
        tick();
        rd_ack   = 1'b0;
        in_xfer  = 1'b1;
        cur_port = g[3:0];
        for (int b = 0; b < int'(pk.len); b++) begin
            repeat ($urandom_range(0, 1)) begin
                mem_vld = 1'b0; mem_sop = 1'b0; mem_eop = 1'b0;
                ready = NP'($urandom);
                tick();
            end
            mem_vld  = 1'b1;
            mem_sop  = (b == 0);
            mem_eop  = (b == int'(pk.len) - 1);
            mem_data = word(pk.seed, 32'(b));
            hold  = (b == hold_beat) ? 2 : 0;
            tries = 0;
            done  = 1'b0;
            while (!done) begin
                rdy = NP'($urandom);
                if (b == rst_beat) begin
                    rdy[g] = 1'b0;
                    ready  = rdy;
                    #1;
                    check(vld === oh(g[3:0]), "pre_rst_vld", vld, oh(g[3:0]));
                    #1;
                    rst = 1'b1;
                    in_xfer = 1'b0;
                    #1;
                    check(vld === '0 && sop === '0 && eop === '0, "rst_beat_qual", {vld, sop, eop}, 0);
                    check(data_out === '0, "rst_data_out", data_out, 0);
                    check({mem_next, busy, rd_req} === 3'b000, "rst_ctrl", {mem_next, busy, rd_req}, 0);
                    tick();
                    rst = 1'b0;
                    mem_vld = 1'b0; mem_sop = 1'b0; mem_eop = 1'b0;
                    void'(pq[g].pop_front());
                    m_cur = NP - 1;
                    m_run = 0;
                    upd_pending();
                    return;
                end
                if (hold > 0) begin
                    rdy[g] = 1'b0;
                    hold--;
                end else begin
                    rdy[g] = ($urandom_range(0, 3) != 0) || (tries >= 3);
                end
                ready = rdy;
                done  = rdy[g];
                tries++;
                tick();
            end
        end
        mem_vld = 1'b0; mem_sop = 1'b0; mem_eop = 1'b0;
        in_xfer = 1'b0;
        void'(pq[g].pop_front());
        upd_pending();
    endtask

    task automatic drain();
        int guard = 0;
        while (pending != '0 && guard < 64) begin
            serve_one(-1, -1);
            guard++;
        end
    endtask

    // Monitor: per-cycle beat qualifiers plus scoreboard pops on grants and transferred beats.
    initial begin
        logic [NP-1:0] ev;
        logic [3:0]    ep;
        beat_t         eb;
        forever begin
            @(negedge clk);
            ev = (in_xfer && mem_vld) ? oh(cur_port) : '0;
            check(vld === ev, "vld", vld, ev);
            check(sop === (mem_sop ? ev : '0), "sop", sop, mem_sop ? ev : '0);
            check(eop === (mem_eop ? ev : '0), "eop", eop, mem_eop ? ev : '0);
            check(data_out === (in_xfer ? mem_data : '0), "data_out", data_out, in_xfer ? mem_data : '0);
            check(mem_next === (in_xfer && mem_vld && ready[cur_port]), "mem_next", mem_next,
                  in_xfer && mem_vld && ready[cur_port]);
            check(err === 1'b0, "err", err, 0);
            if (in_xfer) check({busy, rd_req} === 2'b10, "xfer_busy", {busy, rd_req}, 2'b10);
            if (rd_req && rd_ack) begin
                if (exp_port_q.size() == 0) check(1'b0, "grant_unexpected", rd_port, 0);
                else begin
                    ep = exp_port_q.pop_front();
                    check(rd_port === ep, "grant_port", rd_port, ep);
                end
            end
            if (mem_next) begin
                if (exp_beat_q.size() == 0) check(1'b0, "beat_unexpected", vld, 0);
                else begin
                    eb = exp_beat_q.pop_front();
                    check(vld === oh(eb.port), "beat_port", vld, oh(eb.port));
                    check(data_out === word(eb.seed, eb.beat), "beat_data", data_out, word(eb.seed, eb.beat));
                    check(sop === (eb.sop ? oh(eb.port) : '0), "beat_sop", sop, eb.sop ? oh(eb.port) : '0);
                    check(eop === (eb.eop ? oh(eb.port) : '0), "beat_eop", eop, eb.eop ? oh(eb.port) : '0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; sp0_wrr1 = 1'b0; pending = '0; wrr_weight_p = '0; ready = '0;
        rd_ack = 1'b0; mem_vld = 1'b0; mem_sop = 1'b0; mem_eop = 1'b0; mem_data = '0;
        #2;
        check({busy, rd_req, mem_next, err} === 4'b0000, "reset_ctrl", {busy, rd_req, mem_next, err}, 0);
        check(rd_port === 4'd0, "reset_rd_port", rd_port, 0);
        check({vld, sop, eop} === '0, "reset_qual", {vld, sop, eop}, 0);
        check(data_out === '0, "reset_data_out", data_out, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Strict priority: port 2 wins twice over port 4.
        add_pkt(2, 2); add_pkt(2, 1); add_pkt(4, 1);
        upd_pending();
        drain();

        // WRR with weights 2 and 1 on ports 0 and 1.
        sp0_wrr1 = 1'b1;
        wrr_weight_p = 64'h12;
        for (int i = 0; i < 4; i++) add_pkt(0, 1 + (i % 2));
        add_pkt(1, 2); add_pkt(1, 1);
        upd_pending();
        drain();

        // Only the top port requests: the search wraps back onto itself.
        for (int i = 0; i < 3; i++) add_pkt(15, 1);
        upd_pending();
        drain();

        // Beat 2 of a 3-beat packet stalled by ready.
        add_pkt(5, 3);
        upd_pending();
        serve_one(1, -1);

        // Reset mid-packet, then ports 2 and 9 must be served starting from port 0's side.
        add_pkt(3, 4);
        upd_pending();
        serve_one(-1, 1);
        add_pkt(2, 1); add_pkt(9, 2);
        upd_pending();
        drain();

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0 || pending == '0) begin
                repeat ($urandom_range(1, 3)) add_pkt(int'($urandom_range(0, NP - 1)), int'($urandom_range(1, 4)));
            end
            if ($urandom_range(0, 4) == 0) sp0_wrr1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) wrr_weight_p = {$urandom, $urandom};
            upd_pending();
            serve_one(-1, -1);
        end
        drain();

        repeat (3) tick();
        check(exp_port_q.size() == 0, "grants_left", 32'(exp_port_q.size()), 0);
        check(exp_beat_q.size() == 0, "beats_left", 32'(exp_beat_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/read_arbiter.md
READ_ARBITER -- requirements
Module: read_arbiter

Interface
REQ-001 Parameter arbiter_data_width, default 256, beat width in bits.
REQ-002 Parameter num_of_ports, default 16, number of output ports; port index width PW = clog2(num_of_ports).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sp0_wrr1  input  1  0 = strict priority, 1 = weighted round robin.
REQ-006 pending  input  num_of_ports  bit i = port i has at least one queued packet.
REQ-007 wrr_weight_p  input  4*num_of_ports  packed per-port weight, port i at bits [4i+3:4i].
REQ-008 ready  input  num_of_ports  port i can accept a beat.
REQ-009 rd_req / rd_port  output  1 / PW  packet read request and target port to SRAM controller.
REQ-010 rd_ack  input  1  SRAM controller accepts rd_req.
REQ-011 mem_vld, mem_sop, mem_eop  input  1 each  beat qualifiers from SRAM.
REQ-012 mem_data  input  arbiter_data_width  beat payload.
REQ-013 mem_next  output  1  pop current SRAM beat.
REQ-014 vld, sop, eop  output  num_of_ports each  one-hot per-port beat qualifiers.
REQ-015 data_out  output  arbiter_data_width  beat payload, shared by all ports.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 err  output  1  one-cycle timeout pulse (only with READ_ARB_TIMEOUT_EN).

Function
REQ-018 FSM states IDLE, ARB, REQ, XFER; IDLE->ARB when pending != 0.
REQ-019 ARB (one cycle): select port, latch into sel; sp0_wrr1 sampled only here; ->REQ.
REQ-020 Strict priority: lowest-index set bit of pending wins.
REQ-021 WRR: rotating pointer; current pointer port keeps grant while pending and credit < weight; otherwise next set bit searching upward from pointer+1 with wrap-around; weight 0 treated as 1.
REQ-022 WRR credit counter increments per granted packet, clears and pointer advances to granted port on switch.
REQ-023 REQ: rd_req=1, rd_port=sel until cycle with rd_ack=1, then ->XFER; pending deassertion in REQ ignored.
REQ-024 XFER: vld[sel]=mem_vld, sop[sel]=mem_sop, eop[sel]=mem_eop, data_out=mem_data combinationally (zero latency); all other port bits 0.
REQ-025 mem_next = state==XFER && mem_vld && ready[sel]; a beat is transferred only when mem_next=1.
REQ-026 ready[sel] low holds the beat; ready of non-selected ports ignored.
REQ-027 Transferred beat with mem_eop=1 -> IDLE; single-beat packet (sop&eop) legal.
REQ-028 Outside XFER vld/sop/eop/mem_next = 0 and data_out = 0.
REQ-029 Minimum request-to-first-beat: pending rise at cycle t -> rd_req at t+2.

Reset
REQ-030 rst asserted at any time, including mid-packet: state IDLE, sel 0, WRR pointer num_of_ports-1 (so port 0 searched first), credit 0, all outputs 0 asynchronously; truncated packet not resumed.

Configuration
REQ-031 READ_ARB_TIMEOUT_EN defined: 8-bit counter clears on state change or transferred beat, increments in REQ/XFER; at 255 pulses err one cycle and forces IDLE.
REQ-032 READ_ARB_TIMEOUT_EN undefined: no counter, err tied 0, REQ/XFER wait indefinitely.

Structure
REQ-033 Shared package holds FSM state encoding, default width/port constants, timeout limit 255.
REQ-034 One sub-module rr_pick: combinational masked lowest-set-bit finder (request vector, start index -> grant index, any) used for both modes.

Verification
REQ-035 pending=16'h0014, sp0_wrr1=0 -> rd_port=2; after eop, rd_port=2 again while bit 2 set.
REQ-036 sp0_wrr1=1, pending=16'h0003, weights port0=2, port1=1 -> grant order 0,0,1,0,0,1.
REQ-037 pending=16'h8000 only, pointer 15, WRR -> grant 15 repeatedly (wrap-around to self).
REQ-038 3-beat packet to port 5, ready[5] low for 2 cycles on beat 2 -> mem_next low, vld[5]/data_out held, 3 beats delivered, eop[5] on last.
REQ-039 rst asserted during beat 2 of 4 -> all outputs 0 same cycle, busy=0; after release a new packet arbitrates normally.
REQ-040 With READ_ARB_TIMEOUT_EN, rd_ack held 0 -> err pulse 255 cycles after entering REQ, state IDLE next cycle.
